// File: rtl/mdu_mul_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply sequencer.
package mdu_pkg;
    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_MTHI  = 2'b10,
        OP_MTLO  = 2'b11
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DATA_W_DEF  = 32;
    localparam int MUL_LAT_DEF = 7;
endpackage

// File: rtl/mdu_mul_ctrl_if.sv
// EX-stage request / HI-LO result bundle between the CPU and the sequencer.
interface mdu_mul_ctrl_if #(parameter int DATA_W = 32);
    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (output start, op, rs_val, rt_val, input busy, done, hi, lo);
    modport slave  (input start, op, rs_val, rt_val, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_mul_ctrl_abs_neg.sv
// Conditional two's-complement negate; used for operand magnitude and product sign fix.
module mdu_abs_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);
    assign res_o = neg_i ? (~val_i + W'(1)) : val_i;
endmodule

// File: rtl/mdu_mul_ctrl.sv
// HI/LO sequencer: feeds the shared unsigned pipelined multiplier, waits out its
// latency, sign-corrects MULT results and commits HI/LO; also handles MTHI/MTLO.
module mdu_mul_ctrl
    import mdu_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    mdu_mul_ctrl_if.slave         ex,
    output logic [DATA_W-1:0]     mul_a,
    output logic [DATA_W-1:0]     mul_b,
    input  logic [2*DATA_W-1:0]   mul_p
);
    localparam int             CW       = $clog2(MUL_LAT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(MUL_LAT);

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic                busy_q, done_q, neg_q;
    logic [DATA_W-1:0]   hi_q, lo_q, mul_a_q, mul_b_q;

    logic [DATA_W-1:0]   a_abs_d, b_abs_d;
    logic [2*DATA_W-1:0] prod_d;
    op_e                 op;

    assign op = op_e'(ex.op);

    mdu_abs_neg #(.W(DATA_W)) u_abs_a (
        .val_i (ex.rs_val),
        .neg_i (ex.rs_val[DATA_W-1]),
        .res_o (a_abs_d)
    );

    mdu_abs_neg #(.W(DATA_W)) u_abs_b (
        .val_i (ex.rt_val),
        .neg_i (ex.rt_val[DATA_W-1]),
        .res_o (b_abs_d)
    );

    // Sign fix sits on the commit edge itself, so no extra cycle is spent on it.
    mdu_abs_neg #(.W(2*DATA_W)) u_prod (
        .val_i (mul_p),
        .neg_i (neg_q),
        .res_o (prod_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ex.start) begin
                        case (op)
                            OP_MULTU, OP_MULT: begin
                                mul_a_q <= (op == OP_MULT) ? a_abs_d : ex.rs_val;
                                mul_b_q <= (op == OP_MULT) ? b_abs_d : ex.rt_val;
                                neg_q   <= (op == OP_MULT) &
                                           (ex.rs_val[DATA_W-1] ^ ex.rt_val[DATA_W-1]);
                                cnt_q   <= '0;
                                busy_q  <= 1'b1;
                                state_q <= RUN;
                            end
                            OP_MTHI: begin
                                hi_q   <= ex.rs_val;
                                done_q <= 1'b1;
                            end
                            default: begin
                                lo_q   <= ex.rs_val;
                                done_q <= 1'b1;
                            end
                        endcase
                    end
                end
                RUN: begin
                    // Requests arriving here are dropped; the CPU is stalled on busy.
                    if (cnt_q == CNT_LAST) begin
                        {hi_q, lo_q} <= prod_d;
                        done_q       <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ex.busy = busy_q;
    assign ex.done = done_q;
    assign ex.hi   = hi_q;
    assign ex.lo   = lo_q;
    assign mul_a   = mul_a_q;
    assign mul_b   = mul_b_q;
endmodule
